// File: rtl/list_walk_pkg.sv
// ============================================================================
// Module      : list_walk_pkg
// Description : Shared defaults, FSM state type and helpers for list_walk_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package list_walk_pkg;

    localparam int         LWS_PTR_W    = 8;
    localparam logic [7:0] LWS_NULL_PTR = 8'hFF;
    localparam int         LWS_MAX_LEN  = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } lws_state_t;

    // Increment with wrap at n, used to advance the round-robin pointer.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/list_walk_sched_rr_arb.sv
// ============================================================================
// Module      : rr_arb
// Description : Combinational round-robin arbiter; grants the first request at
//               or after rr_ptr, wrapping, as one-hot plus index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    localparam int c_pw = IDX_W + 1;

    logic [c_pw-1:0] w_pos;
    logic            w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = {1'b0, rr_ptr} + c_pw'(k);
            if (w_pos >= c_pw'(N_REQ)) begin
                w_pos = w_pos - c_pw'(N_REQ);
            end
            if (!w_found && req[w_pos[IDX_W-1:0]]) begin
                w_found                 = 1'b1;
                gnt[w_pos[IDX_W-1:0]]   = 1'b1;
                gnt_idx                 = w_pos[IDX_W-1:0];
            end
        end
    end

    assign gnt_vld = w_found;

endmodule

`default_nettype wire

// File: rtl/list_walk_sched.sv
// ============================================================================
// Module      : list_walk_sched
// Description : Round-robin scheduler sharing one linked-list walker between
//               N_REQ requesters. Optional loop guard: LWS_LOOP_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module list_walk_sched
    import list_walk_pkg::*;
#(
    parameter int               N_REQ    = 4,
    parameter int               PTR_W    = LWS_PTR_W,
    parameter logic [PTR_W-1:0] NULL_PTR = LWS_NULL_PTR
`ifdef LWS_LOOP_GUARD_EN
    ,
    parameter int               MAX_LEN  = LWS_MAX_LEN
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    input  logic [N_REQ*PTR_W-1:0]     req_ptr,
    output logic [N_REQ-1:0]           req_rdy,
    output logic                       mem_rd_en,
    output logic [PTR_W-1:0]           mem_rd_addr,
    input  logic [PTR_W-1:0]           mem_rd_data,
    output logic [PTR_W-1:0]           out_ptr,
    output logic                       out_ptr_vld,
    output logic [$clog2(N_REQ)-1:0]   out_id,
    output logic                       out_last,
    input  logic                       out_rdy,
    output logic                       done_vld,
    output logic [$clog2(N_REQ)-1:0]   done_id,
    output logic [PTR_W-1:0]           done_len,
    output logic                       done_err
);

    localparam int c_idx_w = $clog2(N_REQ);

    lws_state_t         r_state;
    lws_state_t         w_state_nxt;
    logic [PTR_W-1:0]   r_cur;
    logic [PTR_W-1:0]   r_nxt;
    logic [PTR_W-1:0]   r_len;
    logic [c_idx_w-1:0] r_id;
    logic [c_idx_w-1:0] r_rr_ptr;
    logic               r_done_vld;
    logic [c_idx_w-1:0] r_done_id;
    logic [PTR_W-1:0]   r_done_len;
    logic               r_done_err;

    logic [N_REQ-1:0]   w_gnt;
    logic [c_idx_w-1:0] w_gnt_idx;
    logic               w_gnt_vld;
    logic [PTR_W-1:0]   w_start_ptr;
    logic               w_guard_hit;
    logic               w_last;

    rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (c_idx_w)
    ) u_rr_arb (
        .req     (req_vld),
        .rr_ptr  (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    assign w_start_ptr = req_ptr[w_gnt_idx*PTR_W +: PTR_W];

`ifdef LWS_LOOP_GUARD_EN
    assign w_guard_hit = (r_state == EMIT) && (r_len == PTR_W'(MAX_LEN - 1));
`else
    assign w_guard_hit = 1'b0;
`endif

    assign w_last = (r_nxt == NULL_PTR) || w_guard_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_rdy     = '0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        out_ptr_vld = 1'b0;
        out_ptr     = '0;
        out_id      = '0;
        out_last    = 1'b0;
        case (r_state)
            IDLE: begin
                req_rdy = w_gnt;
                if (w_gnt_vld && (w_start_ptr != NULL_PTR)) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = r_cur;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                w_state_nxt = EMIT;
            end
            EMIT: begin
                out_ptr_vld = 1'b1;
                out_ptr     = r_cur;
                out_id      = r_id;
                out_last    = w_last;
                if (out_rdy) begin
                    w_state_nxt = w_last ? IDLE : FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Walk context and completion report; a null start pointer completes at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur      <= '0;
            r_nxt      <= '0;
            r_len      <= '0;
            r_id       <= '0;
            r_rr_ptr   <= '0;
            r_done_vld <= 1'b0;
            r_done_id  <= '0;
            r_done_len <= '0;
            r_done_err <= 1'b0;
        end else begin
            r_done_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_cur    <= w_start_ptr;
                        r_id     <= w_gnt_idx;
                        r_len    <= '0;
                        r_rr_ptr <= c_idx_w'(wrap_inc(int'(w_gnt_idx), N_REQ));
                        if (w_start_ptr == NULL_PTR) begin
                            r_done_vld <= 1'b1;
                            r_done_id  <= w_gnt_idx;
                            r_done_len <= '0;
                            r_done_err <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    r_nxt <= mem_rd_data;
                end
                EMIT: begin
                    if (out_rdy) begin
                        r_len <= r_len + PTR_W'(1);
                        r_cur <= r_nxt;
                        if (w_last) begin
                            r_done_vld <= 1'b1;
                            r_done_id  <= r_id;
                            r_done_len <= r_len + PTR_W'(1);
                            r_done_err <= w_guard_hit && (r_nxt != NULL_PTR);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_vld = r_done_vld;
    assign done_id  = r_done_id;
    assign done_len = r_done_len;
    assign done_err = r_done_err;

endmodule

`default_nettype wire

// File: tb/tb_list_walk_sched.sv
// ============================================================================
// Module      : tb_list_walk_sched
// Description : Self-checking bench for list_walk_sched with a queue-based
//               walk model, a grant table and directed corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_list_walk_sched;

`ifdef LWS_LOOP_GUARD_EN
    localparam bit GUARD      = 1'b1;
`else
    localparam bit GUARD      = 1'b0;
`endif
    localparam int TB_MAX_LEN = 4;

    typedef struct packed {logic [7:0] ptr; logic [1:0] id; logic last;} item_t;
    typedef struct packed {logic [1:0] id; logic [7:0] len; logic err;} done_t;
    typedef struct {logic [3:0] vld; logic [3:0] gnt; logic [1:0] id;} vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_vld;
    logic [31:0] req_ptr;
    logic [3:0]  req_rdy;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic [7:0]  out_ptr;
    logic        out_ptr_vld;
    logic [1:0]  out_id;
    logic        out_last;
    logic        out_rdy;
    logic        done_vld;
    logic [1:0]  done_id;
    logic [7:0]  done_len;
    logic        done_err;

    logic [7:0]  mem [256];
    item_t       exp_q[$];
    done_t       done_q[$];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    list_walk_sched #(
        .N_REQ    (4),
        .PTR_W    (8),
        .NULL_PTR (8'hFF)
`ifdef LWS_LOOP_GUARD_EN
        ,
        .MAX_LEN  (TB_MAX_LEN)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_ptr     (req_ptr),
        .req_rdy     (req_rdy),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_ptr     (out_ptr),
        .out_ptr_vld (out_ptr_vld),
        .out_id      (out_id),
        .out_last    (out_last),
        .out_rdy     (out_rdy),
        .done_vld    (done_vld),
        .done_id     (done_id),
        .done_len    (done_len),
        .done_err    (done_err)
    );

    // Next-pointer RAM: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_done(input string name, input logic [1:0] id, input logic [7:0] len,
                             input logic err, input int limit);
        int k;
        k = 0;
        @(negedge clk);
        while (!done_vld && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(name, {done_vld, done_id, done_len, done_err}, {1'b1, id, len, err});
    endtask

    // Reference model: walks the list from the spec rules at grant time.
    initial begin
        int          m_rr;
        bit          m_busy;
        bit          hold_prev;
        logic [10:0] hold_val;
        int          g;
        int          j;
        int          n;
        logic [3:0]  eg;
        logic [7:0]  cur;
        logic [7:0]  nx;
        bit          lst;
        item_t       e;
        done_t       d;
        m_rr = 0; m_busy = 0; hold_prev = 0; hold_val = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_rr = 0; m_busy = 0; hold_prev = 0;
                exp_q.delete();
                done_q.delete();
            end else begin
                if (hold_prev)
                    chk("hold_stable", {out_ptr_vld, out_ptr, out_id, out_last}, {1'b1, hold_val});
                hold_prev = out_ptr_vld && !out_rdy;
                hold_val  = {out_ptr, out_id, out_last};

                if (req_vld != 4'd0 || req_rdy != 4'd0) begin
                    g = -1; eg = '0;
                    if (!m_busy) begin
                        for (int k = 0; k < 4; k++) begin
                            j = (m_rr + k) % 4;
                            if (g < 0 && req_vld[j]) g = j;
                        end
                    end
                    if (g >= 0) eg[g] = 1'b1;
                    chk("grant", req_rdy, eg);
                    if (g >= 0) begin
                        cur  = req_ptr[g*8 +: 8];
                        m_rr = (g + 1) % 4;
                        if (cur == 8'hFF) begin
                            done_q.push_back({2'(g), 8'd0, 1'b0});
                        end else begin
                            m_busy = 1; n = 0; lst = 0; nx = '0;
                            while (!lst && n < 1000) begin
                                nx  = mem[cur];
                                n++;
                                lst = (nx == 8'hFF) || (GUARD && n == TB_MAX_LEN);
                                exp_q.push_back({cur, 2'(g), lst});
                                cur = nx;
                            end
                            done_q.push_back({2'(g), 8'(n), GUARD && n == TB_MAX_LEN && nx != 8'hFF});
                        end
                    end
                end

                if (out_ptr_vld && out_rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("out_when_idle", out_ptr_vld, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_item", {out_ptr, out_id, out_last}, e);
                        if (e.last) m_busy = 0;
                    end
                end

                if (done_vld) begin
                    if (done_q.size() == 0) begin
                        chk("done_unexpected", done_vld, 0);
                    end else begin
                        d = done_q.pop_front();
                        chk("done_report", {done_id, done_len, done_err}, d);
                    end
                end
            end
        end
    end

    initial begin
        vec_t tbl[12];
        bit   prev_g;
        logic [1:0] prev_id;
        int   hi;
        int   k;

        tbl[0]  = '{4'b1111, 4'b0001, 2'd0};
        tbl[1]  = '{4'b1111, 4'b0010, 2'd1};
        tbl[2]  = '{4'b1111, 4'b0100, 2'd2};
        tbl[3]  = '{4'b1111, 4'b1000, 2'd3};
        tbl[4]  = '{4'b1111, 4'b0001, 2'd0};
        tbl[5]  = '{4'b0001, 4'b0001, 2'd0};
        tbl[6]  = '{4'b1001, 4'b1000, 2'd3};
        tbl[7]  = '{4'b0110, 4'b0010, 2'd1};
        tbl[8]  = '{4'b0000, 4'b0000, 2'd0};
        tbl[9]  = '{4'b0011, 4'b0001, 2'd0};
        tbl[10] = '{4'b1100, 4'b0100, 2'd2};
        tbl[11] = '{4'b0101, 4'b0001, 2'd0};

        rst = 1'b1; req_vld = '0; req_ptr = '1; out_rdy = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {req_rdy, mem_rd_en, mem_rd_addr, out_ptr_vld, out_last, done_vld, done_err}, 0);
        chk("rst_data", {out_ptr, out_id, done_id, done_len}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Grant order with null start pointers: one-cycle walks.
        prev_g = 0; prev_id = '0;
        for (int i = 0; i < 12; i++) begin
            req_vld = tbl[i].vld;
            @(negedge clk);
            chk("tbl_gnt", req_rdy, tbl[i].gnt);
            chk("tbl_done_vld", done_vld, prev_g);
            if (prev_g) chk("tbl_done", {done_id, done_len, done_err}, {prev_id, 8'd0, 1'b0});
            prev_g  = (tbl[i].gnt != 4'd0);
            prev_id = tbl[i].id;
            @(posedge clk); #1;
        end
        req_vld = '0;
        @(negedge clk);
        chk("tbl_done_last", {done_vld, done_id}, {prev_g, prev_id});
        @(posedge clk); #1;

        // Two-element list, latency grant -> first output = 3 cycles.
        mem[3] = 8'd5; mem[5] = 8'hFF;
        req_ptr[8 +: 8] = 8'd3; req_vld = 4'b0010;
        @(negedge clk);
        chk("t1_gnt", req_rdy, 4'b0010);
        @(posedge clk); #1; req_vld = '0;
        @(negedge clk);
        chk("t1_fetch", {mem_rd_en, mem_rd_addr}, {1'b1, 8'd3});
        @(negedge clk);
        chk("t1_wait_quiet", {out_ptr_vld, mem_rd_en}, 0);
        @(negedge clk);
        chk("t1_first_out", {out_ptr_vld, out_ptr, out_id, out_last}, {1'b1, 8'd3, 2'd1, 1'b0});
        wait_done("t1_done", 2'd1, 8'd2, 1'b0, 20);
        @(posedge clk); #1;

        // Backpressure on the first emitted pointer.
        mem[10] = 8'd20; mem[20] = 8'hFF;
        out_rdy = 1'b0;
        req_ptr[24 +: 8] = 8'd10; req_vld = 4'b1000;
        @(negedge clk);
        chk("t3_gnt", req_rdy, 4'b1000);
        @(posedge clk); #1; req_vld = '0;
        k = 0;
        @(negedge clk);
        while (!out_ptr_vld && k < 10) begin @(negedge clk); k++; end
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", {out_ptr_vld, out_ptr, out_id, out_last, mem_rd_en},
                {1'b1, 8'd10, 2'd3, 1'b0, 1'b0});
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1; out_rdy = 1'b1;
        wait_done("t3_done", 2'd3, 8'd2, 1'b0, 20);
        @(posedge clk); #1;

        // Reset while waiting for RAM data abandons the walk.
        req_ptr[16 +: 8] = 8'd3; req_vld = 4'b0100;
        @(negedge clk);
        chk("t5_gnt", req_rdy, 4'b0100);
        @(posedge clk); #1; req_vld = '0;
        @(negedge clk);
        chk("t5_fetch", mem_rd_en, 1'b1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("t5_ctrl_zero", {req_rdy, mem_rd_en, mem_rd_addr, out_ptr_vld, out_last, done_vld, done_err}, 0);
        chk("t5_data_zero", {out_ptr, out_id, done_id, done_len}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_done", {done_vld, out_ptr_vld}, 0);
        end
        @(posedge clk); #1;
        req_ptr = '1; req_vld = 4'b1111;
        @(negedge clk);
        chk("t5_rr_reset", req_rdy, 4'b0001);
        @(posedge clk); #1; req_vld = '0;
        wait_done("t5_done", 2'd0, 8'd0, 1'b0, 5);
        @(posedge clk); #1;

        // A request arriving mid-walk waits, then wins over the previous owner.
        req_ptr[0 +: 8] = 8'd3; req_ptr[16 +: 8] = 8'd5; req_vld = 4'b0001;
        @(negedge clk);
        chk("t6_gnt0", req_rdy, 4'b0001);
        @(posedge clk); #1; req_vld = '0;
        @(posedge clk); #1; req_vld = 4'b0101;
        k = 0;
        @(negedge clk);
        while (req_rdy == 4'd0 && k < 20) begin @(negedge clk); k++; end
        chk("t6_gnt2", req_rdy, 4'b0100);
        chk("t6_done0_coincident", {done_vld, done_id, done_len}, {1'b1, 2'd0, 8'd2});
        @(posedge clk); #1; req_vld = '0;
        wait_done("t6_done2", 2'd2, 8'd1, 1'b0, 20);
        @(posedge clk); #1;

`ifdef LWS_LOOP_GUARD_EN
        // Self-loop truncated by the guard.
        mem[7] = 8'd7;
        req_ptr[8 +: 8] = 8'd7; req_vld = 4'b0010;
        @(negedge clk);
        chk("t4_gnt", req_rdy, 4'b0010);
        @(posedge clk); #1; req_vld = '0;
        wait_done("t4_done", 2'd1, 8'd4, 1'b1, 40);
        @(posedge clk); #1;
`endif

        // Random acyclic lists, random requests and backpressure.
        for (int i = 0; i < 256; i++) begin
            if (i >= 250 || $urandom_range(0, 3) == 0) begin
                mem[i] = 8'hFF;
            end else begin
                hi = 254 - (i + 1);
                if (hi > 30) hi = 30;
                mem[i] = 8'(i + 1 + int'($urandom_range(0, hi)));
            end
        end
        for (int c = 0; c < 2000; c++) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                req_vld = 4'($urandom);
                for (int r = 0; r < 4; r++)
                    req_ptr[r*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
            end
            @(posedge clk); #1;
        end
        req_vld = '0; out_rdy = 1'b1;
        for (int c = 0; c < 3000 && (exp_q.size() != 0 || done_q.size() != 0); c++) @(negedge clk);
        @(negedge clk);
        chk("drain_items", exp_q.size(), 0);
        chk("drain_done", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
